// File: rtl/arp_arb_pkg.sv
// Shared types and helpers for the ARP lookup arbiter.
// Contents: FSM state encoding (one-hot), MAC/IP widths, and log2 for index and counter widths.
// Optional feature macro used by the top: ARP_ARB_TIMEOUT_EN (watchdog plus DRAIN state).
package arp_arb_pkg;

  localparam int MAC_W = 48;
  localparam int IP_W  = 32;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_DRAIN = 4'b1000
  } arb_state_e;

  // Ceiling log2 with a floor of 1, so that a 1-bit index is still legal.
  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/arp_lookup_arbiter_if.sv
// Handshake bundles around the ARP lookup arbiter.
// arp_req_if : requester side (req/req_ip in, done/result out); master = requesters, slave = arbiter.
// arp_eng_if : engine side (start pulse/search ip out, done/result in); master = arbiter, slave = engine.
interface arp_req_if import arp_arb_pkg::*; #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*IP_W-1:0] req_ip;
  logic [NUM_REQ-1:0]      done;
  logic [MAC_W-1:0]        result_mac;
  logic                    result_miss;
  logic                    result_timeout;

  modport master (
    output req, req_ip,
    input  done, result_mac, result_miss, result_timeout
  );
  modport slave (
    input  req, req_ip,
    output done, result_mac, result_miss, result_timeout
  );
endinterface

interface arp_eng_if import arp_arb_pkg::*; ();
  logic             arp_lookup_req;
  logic [IP_W-1:0]  arp_search_ip;
  logic             arp_lookup_done;
  logic [MAC_W-1:0] arp_result_mac;

  modport master (
    output arp_lookup_req, arp_search_ip,
    input  arp_lookup_done, arp_result_mac
  );
  modport slave (
    input  arp_lookup_req, arp_search_ip,
    output arp_lookup_done, arp_result_mac
  );
endinterface

// File: rtl/arp_lookup_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above rr_ptr_i, wrapping at NUM_REQ.
// Ports: req_i (request vector), rr_ptr_i (search start) -> grant_valid_o, grant_idx_o.
// No state; the owner updates the pointer after a grant.
module rr_arbiter import arp_arb_pkg::*; #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [log2(NUM_REQ)-1:0]  rr_ptr_i,
  output logic                      grant_valid_o,
  output logic [log2(NUM_REQ)-1:0]  grant_idx_o
);

  localparam int GW = log2(NUM_REQ);

  always_comb begin
    int idx;
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    idx           = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(rr_ptr_i) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_valid_o && req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/arp_lookup_arbiter.sv
// Shares one ARP lookup engine among NUM_REQ requesters, round-robin, one lookup in flight.
// Ports: clk, reset (sync, active-high), req_if (requester side), eng_if (engine side), busy.
// Macro ARP_ARB_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog in WAIT and a DRAIN state.
module arp_lookup_arbiter import arp_arb_pkg::*; #(
  parameter int NUM_REQ = 4
`ifdef ARP_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic      clk,
  input  logic      reset,
  arp_req_if.slave  req_if,
  arp_eng_if.master eng_if,
  output logic      busy
);

  localparam int GW = log2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]      grant_idx_q, grant_idx_d;
  logic [IP_W-1:0]    search_ip_q, search_ip_d;
  logic               lookup_req_q, lookup_req_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [MAC_W-1:0]   result_mac_q, result_mac_d;
  logic               result_miss_q, result_miss_d;

`ifdef ARP_ARB_TIMEOUT_EN
  localparam int CNT_W = log2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               result_timeout_q, result_timeout_d;
`endif

  logic               grant_valid;
  logic [GW-1:0]      grant_idx;
  logic [NUM_REQ-1:0] req_masked;

  // The requester just served still holds req during its done cycle; that
  // bit only counts as a fresh request from the following cycle.
  assign req_masked = req_if.req & ~done_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i         (req_masked),
    .rr_ptr_i      (rr_ptr_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_idx_d   = grant_idx_q;
    search_ip_d   = search_ip_q;
    lookup_req_d  = 1'b0;
    done_d        = '0;
    result_mac_d  = result_mac_q;
    result_miss_d = result_miss_q;
`ifdef ARP_ARB_TIMEOUT_EN
    wait_cnt_d       = wait_cnt_q;
    result_timeout_d = result_timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          grant_idx_d = grant_idx;
          rr_ptr_d    = (grant_idx == GW'(NUM_REQ - 1)) ? '0 : grant_idx + GW'(1);
          search_ip_d = req_if.req_ip[int'(grant_idx)*IP_W +: IP_W];
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        lookup_req_d = 1'b1;
        state_d      = ST_WAIT;
`ifdef ARP_ARB_TIMEOUT_EN
        wait_cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        // An engine done in the same cycle as the watchdog limit takes priority.
        if (eng_if.arp_lookup_done) begin
          result_mac_d        = eng_if.arp_result_mac;
          result_miss_d       = (eng_if.arp_result_mac == '0);
          done_d[grant_idx_q] = 1'b1;
          state_d             = ST_IDLE;
`ifdef ARP_ARB_TIMEOUT_EN
          result_timeout_d    = 1'b0;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          result_mac_d        = '0;
          result_miss_d       = 1'b1;
          result_timeout_d    = 1'b1;
          done_d[grant_idx_q] = 1'b1;
          state_d             = ST_DRAIN;
        end else begin
          wait_cnt_d          = wait_cnt_q + CNT_W'(1);
`endif
        end
      end
`ifdef ARP_ARB_TIMEOUT_EN
      // The engine is still searching for the abandoned request; keep the IP
      // stable and swallow its eventual done before starting anything new.
      ST_DRAIN: begin
        if (eng_if.arp_lookup_done) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      grant_idx_q   <= '0;
      search_ip_q   <= '0;
      lookup_req_q  <= 1'b0;
      done_q        <= '0;
      result_mac_q  <= '0;
      result_miss_q <= 1'b0;
`ifdef ARP_ARB_TIMEOUT_EN
      wait_cnt_q       <= '0;
      result_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_idx_q   <= grant_idx_d;
      search_ip_q   <= search_ip_d;
      lookup_req_q  <= lookup_req_d;
      done_q        <= done_d;
      result_mac_q  <= result_mac_d;
      result_miss_q <= result_miss_d;
`ifdef ARP_ARB_TIMEOUT_EN
      wait_cnt_q       <= wait_cnt_d;
      result_timeout_q <= result_timeout_d;
`endif
    end
  end

  assign req_if.done           = done_q;
  assign req_if.result_mac     = result_mac_q;
  assign req_if.result_miss    = result_miss_q;
`ifdef ARP_ARB_TIMEOUT_EN
  assign req_if.result_timeout = result_timeout_q;
`else
  assign req_if.result_timeout = 1'b0;
`endif
  assign eng_if.arp_lookup_req = lookup_req_q;
  assign eng_if.arp_search_ip  = search_ip_q;
  // One-hot encoding: IDLE is bit 0 of the state register.
  assign busy                  = ~state_q[0];

endmodule

// File: tb/tb_arp_lookup_arbiter.sv
module tb_arp_lookup_arbiter;

  logic clk;
  logic reset;
  logic busy;

  arp_req_if #(.NUM_REQ(4)) rq ();
  arp_eng_if eng ();

  arp_lookup_arbiter #(
    .NUM_REQ(4)
`ifdef ARP_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req_if (rq.slave),
    .eng_if (eng.master),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int n_issue = 0;
  int exp_issues = 0;

  // Counts every cycle the engine start pulse is high.
  always @(posedge clk) if (!reset && eng.arp_lookup_req) n_issue++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ip(input int idx, input logic [31:0] ip);
    rq.req_ip[idx*32 +: 32] = ip;
  endtask

  task automatic wait_issue(input string tag);
    int n;
    n = 0;
    while (!eng.arp_lookup_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_issue"}, 64'(eng.arp_lookup_req), 64'd1);
    exp_issues++;
  endtask

  // Engine returns mac; the served requester must see done on the next cycle.
  task automatic complete(input string tag, input int idx, input logic [47:0] mac);
    eng.arp_lookup_done = 1'b1;
    eng.arp_result_mac  = mac;
    tick();
    eng.arp_lookup_done = 1'b0;
    eng.arp_result_mac  = 48'h0;
    check({tag, "_done"},    64'(rq.done), 64'(1) << idx);
    check({tag, "_mac"},     64'(rq.result_mac), 64'(mac));
    check({tag, "_miss"},    64'(rq.result_miss), (mac == 48'h0) ? 64'd1 : 64'd0);
    check({tag, "_tmo"},     64'(rq.result_timeout), 64'd0);
    check({tag, "_reqlow"},  64'(eng.arp_lookup_req), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    reset               = 1'b1;
    rq.req              = 4'b0000;
    rq.req_ip           = '0;
    eng.arp_lookup_done = 1'b0;
    eng.arp_result_mac  = 48'h0;
    tick();
    tick();

    // Reset state
    check("rst_done",   64'(rq.done), 64'd0);
    check("rst_mac",    64'(rq.result_mac), 64'd0);
    check("rst_miss",   64'(rq.result_miss), 64'd0);
    check("rst_tmo",    64'(rq.result_timeout), 64'd0);
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_lreq",   64'(eng.arp_lookup_req), 64'd0);
    check("rst_ip",     64'(eng.arp_search_ip), 64'd0);
    reset = 1'b0;
    tick();

    // 1: single requester, latency req -> start pulse is two cycles
    set_ip(0, 32'h0A000001);
    rq.req = 4'b0001;
    tick();
    check("t1_busy",  64'(busy), 64'd1);
    check("t1_lreq0", 64'(eng.arp_lookup_req), 64'd0);
    tick();
    check("t1_lreq1", 64'(eng.arp_lookup_req), 64'd1);
    check("t1_ip",    64'(eng.arp_search_ip), 64'h0A000001);
    exp_issues++;
    tick();
    check("t1_pulse", 64'(eng.arp_lookup_req), 64'd0);
    complete("t1", 0, 48'h001122334455);
    rq.req = 4'b0000;
    tick();
    check("t1_done1cyc", 64'(rq.done), 64'd0);
    check("t1_idle",     64'(busy), 64'd0);

    // 2: all four at once from rr_ptr=0 -> served 0,1,2,3
    do_reset();
    for (int i = 0; i < 4; i++) set_ip(i, 32'h0B000000 + 32'(i));
    rq.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_issue($sformatf("t2_g%0d", k));
      check($sformatf("t2_ip%0d", k), 64'(eng.arp_search_ip), 64'h0B000000 + 64'(k));
      complete($sformatf("t2_g%0d", k), k, 48'h0A0000000000 + 48'(k));
      rq.req[k] = 1'b0;
    end

    // 3: engine miss
    set_ip(1, 32'hC0A80005);
    rq.req = 4'b0010;
    wait_issue("t3");
    check("t3_ip", 64'(eng.arp_search_ip), 64'hC0A80005);
    complete("t3", 1, 48'h0);
    rq.req = 4'b0000;

    // 4: req[2] held through its done while req[3] pends -> 2, 3, then 2 again
    set_ip(2, 32'h0C000002);
    set_ip(3, 32'h0C000003);
    rq.req = 4'b1100;
    wait_issue("t4_a");
    complete("t4_a", 2, 48'h222222222222);
    wait_issue("t4_b");
    check("t4_b_ip", 64'(eng.arp_search_ip), 64'h0C000003);
    complete("t4_b", 3, 48'h333333333333);
    rq.req[3] = 1'b0;
    wait_issue("t4_c");
    check("t4_c_ip", 64'(eng.arp_search_ip), 64'h0C000002);
    complete("t4_c", 2, 48'h444444444444);
    rq.req[2] = 1'b0;

    // 5: requester IP changes mid-WAIT; search IP must not follow
    set_ip(0, 32'h0A0A0A0A);
    rq.req = 4'b0001;
    wait_issue("t5");
    set_ip(0, 32'hDEADBEEF);
    tick();
    tick();
    tick();
    check("t5_ip_hold", 64'(eng.arp_search_ip), 64'h0A0A0A0A);
    complete("t5", 0, 48'h5A5A5A5A5A5A);
    rq.req = 4'b0000;
    tick();

    // Spurious engine done while idle is ignored
    eng.arp_lookup_done = 1'b1;
    eng.arp_result_mac  = 48'h000000000123;
    tick();
    eng.arp_lookup_done = 1'b0;
    eng.arp_result_mac  = 48'h0;
    check("spur_done", 64'(rq.done), 64'd0);
    check("spur_busy", 64'(busy), 64'd0);
    check("spur_mac",  64'(rq.result_mac), 64'h5A5A5A5A5A5A);

    // Reset while waiting on the engine: outputs clear, no done pulse
    set_ip(1, 32'h0A000101);
    rq.req = 4'b0010;
    wait_issue("rw");
    tick();
    tick();
    reset  = 1'b1;
    rq.req = 4'b0000;
    tick();
    check("rw_done", 64'(rq.done), 64'd0);
    check("rw_busy", 64'(busy), 64'd0);
    check("rw_ip",   64'(eng.arp_search_ip), 64'd0);
    check("rw_mac",  64'(rq.result_mac), 64'd0);
    reset = 1'b0;
    tick();
    eng.arp_lookup_done = 1'b1;
    eng.arp_result_mac  = 48'h777777777777;
    tick();
    eng.arp_lookup_done = 1'b0;
    eng.arp_result_mac  = 48'h0;
    check("rw_late_done", 64'(rq.done), 64'd0);
    check("rw_late_busy", 64'(busy), 64'd0);

`ifdef ARP_ARB_TIMEOUT_EN
    // 6: watchdog at 8 WAIT cycles, late engine done drained
    set_ip(2, 32'h0D000002);
    rq.req = 4'b0100;
    wait_issue("t6");
    for (int c = 1; c < 8; c++) begin
      tick();
      check($sformatf("t6_nodone%0d", c), 64'(rq.done), 64'd0);
    end
    tick();
    check("t6_done", 64'(rq.done), 64'b0100);
    check("t6_tmo",  64'(rq.result_timeout), 64'd1);
    check("t6_miss", 64'(rq.result_miss), 64'd1);
    check("t6_mac",  64'(rq.result_mac), 64'd0);
    rq.req = 4'b0000;
    tick();
    tick();
    check("t6_drain_busy", 64'(busy), 64'd1);
    check("t6_drain_ip",   64'(eng.arp_search_ip), 64'h0D000002);
    eng.arp_lookup_done = 1'b1;
    eng.arp_result_mac  = 48'h888888888888;
    tick();
    eng.arp_lookup_done = 1'b0;
    eng.arp_result_mac  = 48'h0;
    check("t6_swallow", 64'(rq.done), 64'd0);
    check("t6_idle",    64'(busy), 64'd0);
`endif

    tick();
    check("issue_count", 64'(n_issue), 64'(exp_issues));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
